// File: rtl/booth_mult_arb_pkg.sv
// booth_arb_pkg: shared types and default sizes for the booth multiplier
// arbiter slice.
//   arb_state_t  : sequencer state encoding (IDLE, START, WAIT, RESP)
//   DEF_NUM_REQ  : default number of requesters
//   DEF_WIDTH    : default operand width
package booth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;

endpackage

// File: rtl/booth_mult_arb_if.sv
// booth_mult_arb_if: request and response bundle between client blocks and
// the multiplier arbiter.
//   req_valid/req_a/req_b/req_ready : per-requester operand handshake
//   resp_valid/resp_ready           : result handshake
//   resp_id/resp_y                  : owner index and signed product
//   resp_err                        : timeout flag, only with BOOTH_ARB_TIMEOUT_EN
// Modports: master = client side, slave = arbiter side.
interface booth_mult_arb_if
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [2*WIDTH-1:0]       resp_y;
`ifdef BOOTH_ARB_TIMEOUT_EN
  logic                     resp_err;

  modport master (output req_valid, req_a, req_b, resp_ready,
                  input  req_ready, resp_valid, resp_id, resp_y, resp_err);
  modport slave  (input  req_valid, req_a, req_b, resp_ready,
                  output req_ready, resp_valid, resp_id, resp_y, resp_err);
`else
  modport master (output req_valid, req_a, req_b, resp_ready,
                  input  req_ready, resp_valid, resp_id, resp_y);
  modport slave  (input  req_valid, req_a, req_b, resp_ready,
                  output req_ready, resp_valid, resp_id, resp_y);
`endif

endinterface

// File: rtl/booth_mult_arb_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req        : request vector
//   last_grant : index granted last; search starts one above it and wraps
//   grant      : first requesting index found
//   any_req    : at least one request present
module rr_pick
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any_req
);
  localparam int ID_W = $clog2(NUM_REQ);

  always_comb begin
    int idx;
    logic [ID_W-1:0] idx_l;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_l   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last_grant) + i) % NUM_REQ;
      idx_l = ID_W'(idx);
      if (!any_req && req[idx_l]) begin
        any_req = 1'b1;
        grant   = idx_l;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arb.sv
// booth_mult_arb: shares one sequential multiplier core between NUM_REQ
// requesters using round-robin arbitration.
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : request/response handshakes, see booth_mult_arb_if
//   mul_start       : one-cycle launch pulse to the core
//   mul_a, mul_b    : operands to the core, stable from START through WAIT
//   mul_y, mul_done : core product and completion pulse
// Optional macro BOOTH_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC
// cycles and the resp_err flag.
//
// state | meaning
// IDLE  | waiting for any request; grant issued combinationally
// START | mul_start high for this cycle only
// WAIT  | core busy; only state that honours mul_done
// RESP  | result held until resp_ready
module booth_mult_arb
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
`ifdef BOOTH_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  booth_mult_arb_if.slave    bus,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_y,
  input  logic               mul_done
);
  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  logic [2*WIDTH-1:0] resp_y_q, resp_y_d;
  logic [ID_W-1:0]    pick_g;
  logic               pick_any;
  logic [NUM_REQ-1:0] req_ready_c;
`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .grant      (pick_g),
    .any_req    (pick_any)
  );

  // Accept strobe is combinational; gated by rst so nothing is accepted
  // while the block is held in reset.
  always_comb begin
    req_ready_c = '0;
    if (rst && state_q == IDLE && pick_any) req_ready_c[pick_g] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    start_d      = 1'b0;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_y_d     = resp_y_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_g;
          start_d = 1'b1;
          state_d = START;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_g == ID_W'(i)) begin
              op_a_d = bus.req_a[i*WIDTH +: WIDTH];
              op_b_d = bus.req_b[i*WIDTH +: WIDTH];
            end
          end
        end
      end
      START: begin
        state_d = WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (mul_done) begin
          resp_y_d     = mul_y;
          resp_id_d    = gnt_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
`ifdef BOOTH_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          resp_y_d     = '0;
          resp_id_d    = gnt_q;
          resp_valid_d = 1'b1;
          err_d        = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        // Pointer moves only here, so a held request cannot be starved.
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          last_d       = gnt_q;
          state_d      = IDLE;
`ifdef BOOTH_ARB_TIMEOUT_EN
          err_d        = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_q       <= ID_W'(NUM_REQ - 1);
      start_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_y_q     <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      start_q      <= start_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_y_q     <= resp_y_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_y     = resp_y_q;
  assign mul_start      = start_q;
  assign mul_a          = op_a_q;
  assign mul_b          = op_b_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign bus.resp_err   = err_q;
`endif

endmodule

// File: tb/tb_booth_mult_arb.sv
// Testbench for booth_mult_arb: behavioural core model plus a reference
// model of round-robin order and signed products.
module tb_booth_mult_arb;
  localparam int NR = 4;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_arb_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  logic         mul_start;
  logic [W-1:0] mul_a, mul_b;
  logic [2*W-1:0] mul_y;
  logic         mul_done, core_done, stray_done;
  assign mul_done = core_done | stray_done;

  booth_mult_arb #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_y     (mul_y),
    .mul_done  (mul_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int core_lat = 6;
  bit core_en  = 1'b1;
  int model_last = NR - 1;
  logic [W-1:0] op_a [NR];
  logic [W-1:0] op_b [NR];

  // Core model: sees the START cycle at a negedge, asserts done for one
  // sample edge core_lat cycles later, abandons the job on reset.
  initial begin
    logic signed [W-1:0] ca, cb;
    logic signed [2*W-1:0] p;
    bit alive;
    core_done = 1'b0;
    mul_y = '0;
    forever begin
      @(negedge clk);
      if (core_en && rst && mul_start === 1'b1) begin
        ca = mul_a; cb = mul_b; alive = 1'b1;
        for (int k = 0; k < core_lat; k++) begin
          @(posedge clk);
          if (!rst) begin alive = 1'b0; break; end
        end
        if (alive) begin
          #1;
          p = ca * cb;
          mul_y = p;
          core_done = 1'b1;
          @(posedge clk);
          #1 core_done = 1'b0;
        end
      end
    end
  end

  function automatic int next_grant(input logic [NR-1:0] mask, input int last);
    for (int i = 1; i <= NR; i++) if (mask[(last + i) % NR]) return (last + i) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int g);
    logic [NR-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    return (2*W)'(sa * sb);
  endfunction

  task automatic update_ops();
    bus.req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    bus.req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
  endtask

  task automatic rand_op(input int i);
    op_a[i] = W'($urandom);
    op_b[i] = W'($urandom);
    update_ops();
  endtask

  // Called at negedge+1; returns at negedge+1 with the first nonzero req_ready.
  task automatic wait_grant(output logic [NR-1:0] rr, output bit ok);
    ok = 1'b0; rr = '0;
    #1;
    for (int k = 0; k < 50; k++) begin
      if (bus.req_ready !== '0) begin rr = bus.req_ready; ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_resp(output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.resp_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk); #1; n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    model_last = NR - 1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) rand_op(i);
    bus.req_valid = '1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.req_ready !== '0) $display("FAIL reset_ready: got %b want 0", bus.req_ready); else n_pass++;
    n_checks++;
    if ({mul_start, mul_a, mul_b} !== '0) $display("FAIL reset_mul: got %b/%h/%h want 0", mul_start, mul_a, mul_b); else n_pass++;
    n_checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_y} !== '0)
      $display("FAIL reset_resp: got %b/%0d/%h want 0", bus.resp_valid, bus.resp_id, bus.resp_y); else n_pass++;
    bus.req_valid = '0;
    rst = 1'b1;
    model_last = NR - 1;
    @(negedge clk); #1;
    n_checks++;
    if (bus.req_ready !== '0 || mul_start !== 1'b0) $display("FAIL idle_quiet: got %b/%b want 0/0", bus.req_ready, mul_start); else n_pass++;
  endtask

  task automatic test_single();
    int n; bit ok;
    core_lat = 6;
    op_a[2] = 4'h4; op_b[2] = 4'hB; update_ops();
    bus.req_valid = 4'b0100;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", bus.req_ready); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = '0;
    n_checks++;
    if ({bus.req_ready, mul_start, mul_a, mul_b} !== {4'b0000, 1'b1, 4'h4, 4'hB})
      $display("FAIL single_start: got %b/%b/%h/%h want 0000/1/4/b", bus.req_ready, mul_start, mul_a, mul_b); else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({mul_start, mul_a, mul_b} !== {1'b0, 4'h4, 4'hB})
      $display("FAIL single_wait: got %b/%h/%h want 0/4/b", mul_start, mul_a, mul_b); else n_pass++;
    wait_resp(n, ok);
    n_checks++;
    if (ok !== 1'b1 || n !== core_lat) $display("FAIL single_latency: got ok=%0d n=%0d want 1/%0d", ok, n, core_lat); else n_pass++;
    n_checks++;
    if ({bus.resp_id, bus.resp_y} !== {2'd2, 8'hEC}) $display("FAIL single_resp: got %0d/%h want 2/ec", bus.resp_id, bus.resp_y); else n_pass++;
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    bus.resp_ready = 1'b0;
    model_last = 2;
    n_checks++;
    if (bus.resp_valid !== 1'b0) $display("FAIL single_clear: got %b want 0", bus.resp_valid); else n_pass++;
  endtask

  task automatic test_contention();
    logic [NR-1:0] rr; bit ok; int n, g;
    logic [W-1:0] ea, eb;
    do_reset();
    for (int i = 0; i < NR; i++) rand_op(i);
    bus.resp_ready = 1'b1;
    bus.req_valid = '1;
    for (int t = 0; t < 5; t++) begin
      g = next_grant(4'hF, model_last);
      wait_grant(rr, ok);
      n_checks++;
      if (ok !== 1'b1 || rr !== onehot(g)) $display("FAIL cont_grant%0d: got %b want %b", t, rr, onehot(g)); else n_pass++;
      ea = op_a[g]; eb = op_b[g];
      core_lat = $urandom_range(1, 8);
      @(negedge clk); #1;
      rand_op(g);
      wait_resp(n, ok);
      n_checks++;
      if (ok !== 1'b1 || bus.resp_id !== 2'(g) || bus.resp_y !== exp_prod(ea, eb))
        $display("FAIL cont_resp%0d: got ok=%0d id=%0d y=%h want id=%0d y=%h", t, ok, bus.resp_id, bus.resp_y, g, exp_prod(ea, eb));
      else n_pass++;
      model_last = g;
      @(negedge clk); #1;
    end
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] rr; bit ok; int n, r, g2;
    logic [2*W-1:0] ey;
    r = $urandom_range(0, NR - 1);
    rand_op(r);
    ey = exp_prod(op_a[r], op_b[r]);
    core_lat = $urandom_range(1, 8);
    bus.req_valid = onehot(r);
    wait_grant(rr, ok);
    n_checks++;
    if (ok !== 1'b1 || rr !== onehot(r)) $display("FAIL bp_grant: got %b want %b", rr, onehot(r)); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = '0;
    wait_resp(n, ok);
    n_checks++;
    if (ok !== 1'b1 || bus.resp_id !== 2'(r) || bus.resp_y !== ey)
      $display("FAIL bp_resp: got ok=%0d id=%0d y=%h want id=%0d y=%h", ok, bus.resp_id, bus.resp_y, r, ey); else n_pass++;
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_y, bus.req_ready} !== {1'b1, 2'(r), ey, 4'b0000})
        $display("FAIL bp_hold%0d: got v=%b id=%0d y=%h rdy=%b want 1/%0d/%h/0000", k, bus.resp_valid, bus.resp_id, bus.resp_y, bus.req_ready, r, ey);
      else n_pass++;
    end
    bus.resp_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== '0) $display("FAIL bp_hs_ready: got %b want 0000", bus.req_ready); else n_pass++;
    @(negedge clk); #1;
    bus.resp_ready = 1'b0;
    model_last = r;
    g2 = next_grant(4'hF, model_last);
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== onehot(g2))
      $display("FAIL bp_after: got v=%b rdy=%b want 0/%b", bus.resp_valid, bus.req_ready, onehot(g2)); else n_pass++;
    // Withdraw before the edge: the offered grant must vanish without effect.
    bus.req_valid = '0;
    @(negedge clk); #1;
    n_checks++;
    if (mul_start !== 1'b0 || bus.req_ready !== '0) $display("FAIL bp_withdraw: got start=%b rdy=%b want 0/0000", mul_start, bus.req_ready); else n_pass++;
  endtask

  task automatic test_stray_done();
    logic [NR-1:0] rr; bit ok; int n, r, g;
    logic [2*W-1:0] ey;
    stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || mul_start !== 1'b0) $display("FAIL stray_idle: got v=%b start=%b want 0/0", bus.resp_valid, mul_start); else n_pass++;
    r = $urandom_range(0, NR - 1);
    rand_op(r);
    ey = exp_prod(op_a[r], op_b[r]);
    core_lat = 6;
    bus.req_valid = onehot(r);
    g = next_grant(onehot(r), model_last);
    wait_grant(rr, ok);
    n_checks++;
    if (ok !== 1'b1 || rr !== onehot(g)) $display("FAIL stray_grant: got %b want %b", rr, onehot(g)); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = '0;
    stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    @(negedge clk); #1;
    wait_resp(n, ok);
    n_checks++;
    if (ok !== 1'b1 || n !== core_lat) $display("FAIL stray_latency: got ok=%0d n=%0d want 1/%0d", ok, n, core_lat); else n_pass++;
    n_checks++;
    if (bus.resp_id !== 2'(g) || bus.resp_y !== ey) $display("FAIL stray_resp: got %0d/%h want %0d/%h", bus.resp_id, bus.resp_y, g, ey); else n_pass++;
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    bus.resp_ready = 1'b0;
    model_last = g;
  endtask

  task automatic test_reset_mid_wait();
    logic [NR-1:0] rr; bit ok; int n, r;
    logic [2*W-1:0] e0, e3;
    r = $urandom_range(0, NR - 1);
    rand_op(r);
    core_lat = 8;
    bus.req_valid = onehot(r);
    wait_grant(rr, ok);
    @(negedge clk); #1;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    rand_op(0); rand_op(3);
    e0 = exp_prod(op_a[0], op_b[0]);
    e3 = exp_prod(op_a[3], op_b[3]);
    bus.req_valid = 4'b1001;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, mul_start, mul_a, mul_b, bus.resp_valid, bus.resp_id, bus.resp_y} !== '0)
      $display("FAIL rst_async: got rdy=%b s=%b a=%h b=%h v=%b id=%0d y=%h want all 0", bus.req_ready, mul_start, mul_a, mul_b, bus.resp_valid, bus.resp_id, bus.resp_y);
    else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.req_ready, mul_start, bus.resp_valid} !== '0) $display("FAIL rst_hold: got %b/%b/%b want 0", bus.req_ready, mul_start, bus.resp_valid); else n_pass++;
    rst = 1'b1;
    model_last = NR - 1;
    core_lat = $urandom_range(1, 8);
    #1;
    n_checks++;
    if (bus.req_ready !== onehot(next_grant(4'b1001, model_last))) $display("FAIL rst_first: got %b want 0001", bus.req_ready); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = 4'b1000;
    wait_resp(n, ok);
    n_checks++;
    if (ok !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_y !== e0)
      $display("FAIL rst_resp0: got ok=%0d id=%0d y=%h want 0/%h", ok, bus.resp_id, bus.resp_y, e0); else n_pass++;
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    bus.resp_ready = 1'b0;
    model_last = 0;
    wait_grant(rr, ok);
    n_checks++;
    if (ok !== 1'b1 || rr !== 4'b1000) $display("FAIL rst_grant3: got %b want 1000", rr); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = '0;
    wait_resp(n, ok);
    n_checks++;
    if (ok !== 1'b1 || bus.resp_id !== 2'd3 || bus.resp_y !== e3)
      $display("FAIL rst_resp3: got ok=%0d id=%0d y=%h want 3/%h", ok, bus.resp_id, bus.resp_y, e3); else n_pass++;
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    bus.resp_ready = 1'b0;
    model_last = 3;
  endtask

  task automatic test_timeout();
`ifdef BOOTH_ARB_TIMEOUT_EN
    logic [NR-1:0] rr; bit ok; int n, r;
    core_en = 1'b0;
    r = $urandom_range(0, NR - 1);
    rand_op(r);
    bus.req_valid = onehot(r);
    wait_grant(rr, ok);
    @(negedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk); #1;
    wait_resp(n, ok);
    n_checks++;
    if (ok !== 1'b1 || n !== 32) $display("FAIL to_latency: got ok=%0d n=%0d want 1/32", ok, n); else n_pass++;
    n_checks++;
    if ({bus.resp_err, bus.resp_y, bus.resp_id} !== {1'b1, 8'h00, 2'(r)})
      $display("FAIL to_resp: got err=%b y=%h id=%0d want 1/00/%0d", bus.resp_err, bus.resp_y, bus.resp_id, r); else n_pass++;
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    bus.resp_ready = 1'b0;
    n_checks++;
    if (bus.resp_err !== 1'b0 || bus.resp_valid !== 1'b0) $display("FAIL to_clear: got err=%b v=%b want 0/0", bus.resp_err, bus.resp_valid); else n_pass++;
    core_en = 1'b1;
`endif
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    stray_done     = 1'b0;
    for (int i = 0; i < NR; i++) begin op_a[i] = '0; op_b[i] = '0; end
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_stray_done();
    test_reset_mid_wait();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
